pipe_rca_issue: RTL

Issue/collect stage wrapped around the 4-bit pipelined ripple-carry adder (`pipe_rca_4bit`). It sits directly upstream and downstream of the adder. It accepts operand triples over a valid/ready handshake and drives them into the adder. A valid bit travels alongside each operation through the adder's fixed 4-cycle latency. Returning {Cout, Sum} results are captured into a small first-word-fall-through (FWFT) result FIFO with its own valid/ready handshake. A credit scheme guarantees that no adder result is ever dropped.

---
 rtl/pipe_rca_pkg.sv | 13 +
 rtl/rca_result_fifo.sv | 65 ++++++
 rtl/pipe_rca_issue.sv | 101 ++++++++++
 3 files changed

// File: rtl/pipe_rca_pkg.sv
// Shared types and constants for the pipelined ripple-carry adder issue/collect stage.
// No logic; the adder width and latency here must track the adder instance.
package pipe_rca_pkg;

    localparam int RCA_WIDTH = 4;
    localparam int RCA_LAT   = 4;

    typedef struct packed {
        logic                 cout;
        logic [RCA_WIDTH-1:0] sum;
    } rca_result_t;

endpackage

// File: rtl/rca_result_fifo.sv
// First-word-fall-through result FIFO; head is visible combinationally, write lands next edge.
// Reads are ignored when empty; writes assume the caller's credit scheme keeps it from overflowing.
module rca_result_fifo
    import pipe_rca_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = rca_result_t,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  T              wr_data,
    input  logic          rd_en,
    output T              rd_data,
    output logic [CW-1:0] count
);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_rd;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A full FIFO may still be written when the head is popped in the same cycle.
    assign do_rd = rd_en && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_en ? bump(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_rd ? bump(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !do_rd) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && do_rd) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wr_data;
            end
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/pipe_rca_issue.sv
// Issue/collect around the external LAT-cycle adder: accept -> result visible LAT+1 cycles later.
// in_ready is a credit check on in-flight plus queued results, so adder outputs are never dropped.
module pipe_rca_issue
    import pipe_rca_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH,
    parameter int LAT   = RCA_LAT,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [7:0]       cout_cnt
);

    localparam int CW = $clog2(DEPTH + 1);

    logic          accept;
    logic          pop;
    logic [LAT-1:0] vpipe_q, vpipe_d;
    logic [CW-1:0]  occ_q, occ_d;
    logic [7:0]     cout_cnt_q, cout_cnt_d;
    logic [CW-1:0]  fifo_count;
    rca_result_t    wr_data;
    rca_result_t    rd_data;

    assign in_ready  = occ_q < CW'(DEPTH);
    assign accept    = in_valid && in_ready;
    assign out_valid = fifo_count != '0;
    assign pop       = out_valid && out_ready;

    // Zero the adder inputs when idle so the adder never sees stale operands.
    assign add_a   = accept ? in_a   : '0;
    assign add_b   = accept ? in_b   : '0;
    assign add_cin = accept ? in_cin : 1'b0;

    always_comb begin
        vpipe_d[0] = accept;
        for (int i = 1; i < LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end

        occ_d = occ_q;
        if (accept && !pop) begin
            occ_d = occ_q + CW'(1);
        end else if (!accept && pop) begin
            occ_d = occ_q - CW'(1);
        end

        cout_cnt_d = cout_cnt_q;
        if (pop && out_cout && (cout_cnt_q != 8'hFF)) begin
            cout_cnt_d = cout_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe_q    <= '0;
            occ_q      <= '0;
            cout_cnt_q <= '0;
        end else begin
            vpipe_q    <= vpipe_d;
            occ_q      <= occ_d;
            cout_cnt_q <= cout_cnt_d;
        end
    end

    assign wr_data.cout = add_cout;
    assign wr_data.sum  = add_sum;

    rca_result_fifo #(
        .DEPTH (DEPTH),
        .T     (rca_result_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (vpipe_q[LAT-1]),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (rd_data),
        .count   (fifo_count)
    );

    assign out_sum  = rd_data.sum;
    assign out_cout = rd_data.cout;
    assign cout_cnt = cout_cnt_q;

endmodule
